// File: rtl/collision_pair_scheduler.sv
// collision_pair_scheduler
// Walks every ball-pin and pin-pin pair once per physics frame, skips pairs
// that cannot collide, and issues one request at a time to the shared
// collision resolver. Hit results are folded into a per-pin hit mask and
// per-frame counters.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   start                 frame tick, accepted only when idle
//   ball_active           ball on lane (latched at start)
//   pins_en               pins in play (latched at start)
//   pins_moving           pins with nonzero velocity (latched at start)
//   req_valid/req_ready   pair request handshake to the resolver
//   req_a_idx/req_b_idx   pair indices; a == NUM_PINS denotes the ball
//   resp_valid/resp_hit   resolver result strobe and hit flag
//   busy                  scan in progress
//   done                  single-cycle end-of-scan pulse
//   timeout_err           sticky: last scan aborted on a resolver timeout
//   hit_pins              pins involved in any hit this scan
//   hit_count             number of hit pairs this scan
//   pairs_issued          number of requests accepted this scan
module collision_pair_scheduler #(
    parameter int unsigned NUM_PINS = 10,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned CNT_W    = 6
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                start,
    input  logic                ball_active,
    input  logic [NUM_PINS-1:0] pins_en,
    input  logic [NUM_PINS-1:0] pins_moving,
    output logic                req_valid,
    output logic [IDX_W-1:0]    req_a_idx,
    output logic [IDX_W-1:0]    req_b_idx,
    input  logic                req_ready,
    input  logic                resp_valid,
    input  logic                resp_hit,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic [NUM_PINS-1:0] hit_pins,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    pairs_issued
);

    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] BALL_IDX = IDX_W'(NUM_PINS);
    localparam logic [IDX_W-1:0] LAST_B   = IDX_W'(NUM_PINS - 1);
    // With a single pin there are no pin-pin pairs, so the last pair is a ball pair.
    localparam logic [IDX_W-1:0] LAST_A   = (NUM_PINS >= 2) ? IDX_W'(NUM_PINS - 2) : BALL_IDX;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    a_q, a_d;
    logic [IDX_W-1:0]    b_q, b_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                ball_q, ball_d;
    logic [NUM_PINS-1:0] en_q, en_d;
    logic [NUM_PINS-1:0] mov_q, mov_d;
    logic                req_valid_q, req_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                timeout_err_q, timeout_err_d;
    logic [NUM_PINS-1:0] hit_pins_q, hit_pins_d;
    logic [CNT_W-1:0]    hit_count_q, hit_count_d;
    logic [CNT_W-1:0]    pairs_issued_q, pairs_issued_d;

    logic                is_ball_c;
    logic                eligible_c;
    logic                last_pair_c;
    logic [IDX_W-1:0]    nxt_a_c;
    logic [IDX_W-1:0]    nxt_b_c;

    // Select one bit of a pin mask by index; indices outside the mask read as 0.
    function automatic logic bit_at(input logic [NUM_PINS-1:0] vec,
                                    input logic [IDX_W-1:0]    idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (idx == IDX_W'(i)) begin
                r = vec[i];
            end
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Pair pointer decode: eligibility, last-pair detect, and the next pair in order.
    always_comb begin
        is_ball_c   = (a_q == BALL_IDX);
        eligible_c  = 1'b0;
        last_pair_c = (a_q == LAST_A) && (b_q == LAST_B);
        nxt_a_c     = a_q;
        nxt_b_c     = b_q + IDX_W'(1);

        if (is_ball_c) begin
            eligible_c = ball_q & bit_at(en_q, b_q);
        end else begin
            eligible_c = bit_at(en_q, a_q) & bit_at(en_q, b_q)
                       & (bit_at(mov_q, a_q) | bit_at(mov_q, b_q));
        end

        // At the end of a row, move to the first pin-pin pair of the next row.
        if (b_q == LAST_B) begin
            if (is_ball_c) begin
                nxt_a_c = '0;
                nxt_b_c = IDX_W'(1);
            end else begin
                nxt_a_c = a_q + IDX_W'(1);
                nxt_b_c = a_q + IDX_W'(2);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        timer_d        = timer_q;
        ball_d         = ball_q;
        en_d           = en_q;
        mov_d          = mov_q;
        timeout_err_d  = timeout_err_q;
        hit_pins_d     = hit_pins_q;
        hit_count_d    = hit_count_q;
        pairs_issued_d = pairs_issued_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ball_d         = ball_active;
                    en_d           = pins_en;
                    mov_d          = pins_moving;
                    hit_pins_d     = '0;
                    hit_count_d    = '0;
                    pairs_issued_d = '0;
                    timeout_err_d  = 1'b0;
                    a_d            = BALL_IDX;
                    b_d            = '0;
                    state_d        = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (eligible_c) begin
                    state_d = ST_ISSUE;
                end else if (last_pair_c) begin
                    state_d = ST_DONE;
                end else begin
                    a_d = nxt_a_c;
                    b_d = nxt_b_c;
                end
            end

            ST_ISSUE: begin
                // A resp_valid in this state, even on the handshake cycle, is ignored.
                if (req_valid_q && req_ready) begin
                    pairs_issued_d = sat_inc(pairs_issued_q);
                    timer_d        = '0;
                    state_d        = ST_WAIT;
                end
            end

            ST_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                if (resp_valid) begin
                    if (resp_hit) begin
                        hit_count_d = sat_inc(hit_count_q);
                        for (int i = 0; i < NUM_PINS; i++) begin
                            if ((b_q == IDX_W'(i)) || (!is_ball_c && (a_q == IDX_W'(i)))) begin
                                hit_pins_d[i] = 1'b1;
                            end
                        end
                    end
                    if (last_pair_c) begin
                        state_d = ST_DONE;
                    end else begin
                        a_d     = nxt_a_c;
                        b_d     = nxt_b_c;
                        state_d = ST_SCAN;
                    end
                end else if (timer_q == TMR_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of the upcoming state.
        req_valid_d = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= ST_IDLE;
            a_q            <= '0;
            b_q            <= '0;
            timer_q        <= '0;
            ball_q         <= 1'b0;
            en_q           <= '0;
            mov_q          <= '0;
            req_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            hit_pins_q     <= '0;
            hit_count_q    <= '0;
            pairs_issued_q <= '0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            timer_q        <= timer_d;
            ball_q         <= ball_d;
            en_q           <= en_d;
            mov_q          <= mov_d;
            req_valid_q    <= req_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            timeout_err_q  <= timeout_err_d;
            hit_pins_q     <= hit_pins_d;
            hit_count_q    <= hit_count_d;
            pairs_issued_q <= pairs_issued_d;
        end
    end

    assign req_valid    = req_valid_q;
    assign req_a_idx    = a_q;
    assign req_b_idx    = b_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout_err  = timeout_err_q;
    assign hit_pins     = hit_pins_q;
    assign hit_count    = hit_count_q;
    assign pairs_issued = pairs_issued_q;

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Testbench for collision_pair_scheduler: directed frames plus randomized
// frames, each checked against a pair-list reference model and a cycle-count
// model of the scan.
module tb_collision_pair_scheduler;

    localparam int NP   = 10;
    localparam int IW   = 4;
    localparam int TO   = 64;
    localparam int CW   = 6;
    localparam int NTOT = NP + NP * (NP - 1) / 2;

    logic          clk_in;
    logic          rst_in;
    logic          start;
    logic          ball_active;
    logic [NP-1:0] pins_en;
    logic [NP-1:0] pins_moving;
    logic          req_valid;
    logic [IW-1:0] req_a_idx;
    logic [IW-1:0] req_b_idx;
    logic          req_ready;
    logic          resp_valid;
    logic          resp_hit;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic [NP-1:0] hit_pins;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] pairs_issued;

    int n_checks = 0;
    int n_fail   = 0;

    collision_pair_scheduler #(
        .NUM_PINS(NP), .IDX_W(IW), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start       (start),
        .ball_active (ball_active),
        .pins_en     (pins_en),
        .pins_moving (pins_moving),
        .req_valid   (req_valid),
        .req_a_idx   (req_a_idx),
        .req_b_idx   (req_b_idx),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_hit    (resp_hit),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .hit_pins    (hit_pins),
        .hit_count   (hit_count),
        .pairs_issued(pairs_issued)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full frame: drive start, act as the resolver, then compare against the model.
    task automatic run_frame(input string name, input logic ball,
                             input logic [NP-1:0] en, input logic [NP-1:0] mov,
                             input int rw_min, input int rw_max,
                             input int lat_min, input int lat_max,
                             input bit noresp, input bit spurious,
                             input bit start_busy, input bit always_hit,
                             output int done_cyc);
        int ea[$];
        int eb[$];
        int oa[$];
        int ob[$];
        bit oh[$];
        int p, first_pos, nelig, cyc, done_cnt, first_done;
        int rw, rw_sum, lat_sum, resp_cnt, stab_err, multi_err, mism, exp_pairs, exp_hits, exp_cyc;
        bit in_req, outstanding, cur_hit;
        logic [IW-1:0] cap_a, cap_b;
        logic [NP-1:0] exp_hp;

        // Reference pair list in the defined scan order.
        p = 0;
        first_pos = -1;
        for (int b = 0; b < NP; b++) begin
            if (ball && en[b]) begin
                ea.push_back(NP); eb.push_back(b);
                if (first_pos < 0) first_pos = p;
            end
            p++;
        end
        for (int a = 0; a < NP - 1; a++) begin
            for (int b = a + 1; b < NP; b++) begin
                if (en[a] && en[b] && (mov[a] || mov[b])) begin
                    ea.push_back(a); eb.push_back(b);
                    if (first_pos < 0) first_pos = p;
                end
                p++;
            end
        end
        nelig = ea.size();

        cyc = 0; done_cnt = 0; first_done = -1;
        rw = 0; rw_sum = 0; lat_sum = 0; resp_cnt = 0; stab_err = 0; multi_err = 0;
        in_req = 0; outstanding = 0; cur_hit = 0; cap_a = '0; cap_b = '0;

        ball_active = ball;
        pins_en     = en;
        pins_moving = mov;
        start       = 1'b1;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_hit    = 1'b0;

        while (1) begin
            @(negedge clk_in);
            cyc++;
            start      = 1'b0;
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_hit   = 1'b0;
            if (cyc == 1) begin
                chk($sformatf("%s_terr_clear", name), timeout_err, 0);
                chk($sformatf("%s_busy_start", name), busy, 1);
                // Scramble the live masks: the scan must use the latched copies.
                ball_active = 1'($urandom);
                pins_en     = NP'($urandom);
                pins_moving = NP'($urandom);
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = cyc;
            end
            if (outstanding) begin
                resp_cnt--;
                if (resp_cnt == 0 && !noresp) begin
                    resp_valid  = 1'b1;
                    resp_hit    = cur_hit;
                    outstanding = 0;
                end
            end
            if (req_valid === 1'b1) begin
                if (outstanding) multi_err++;
                if (!in_req) begin
                    in_req = 1;
                    rw = int'($urandom_range(rw_max, rw_min));
                    rw_sum += rw;
                    cap_a = req_a_idx;
                    cap_b = req_b_idx;
                end else if (req_a_idx !== cap_a || req_b_idx !== cap_b) begin
                    stab_err++;
                end
                if (spurious) begin
                    resp_valid = 1'b1;
                    resp_hit   = 1'b1;
                end
                if (rw > 0) begin
                    rw--;
                end else begin
                    req_ready   = 1'b1;
                    in_req      = 0;
                    outstanding = 1;
                    resp_cnt    = int'($urandom_range(lat_max, lat_min));
                    lat_sum    += resp_cnt;
                    cur_hit     = always_hit ? 1'b1 : 1'($urandom);
                    oa.push_back(int'(cap_a));
                    ob.push_back(int'(cap_b));
                    oh.push_back(cur_hit);
                end
            end
            if (start_busy && busy === 1'b1 && done !== 1'b1) start = 1'($urandom);
            if (first_done >= 0 && cyc >= first_done + 3) break;
            if (cyc > 3000) begin
                chk($sformatf("%s_done_seen", name), first_done >= 0, 1);
                break;
            end
        end
        start = 1'b0;

        mism = 0;
        for (int i = 0; i < oa.size() && i < nelig; i++) begin
            if (oa[i] != ea[i] || ob[i] != eb[i]) mism++;
        end

        exp_pairs = (noresp && nelig > 0) ? 1 : nelig;
        exp_hits  = 0;
        exp_hp    = '0;
        if (!noresp) begin
            for (int i = 0; i < oh.size() && i < nelig; i++) begin
                if (oh[i]) begin
                    exp_hits++;
                    exp_hp[eb[i]] = 1'b1;
                    if (ea[i] != NP) exp_hp[ea[i]] = 1'b1;
                end
            end
        end
        if (noresp && nelig > 0) exp_cyc = (first_pos + 1) + 1 + rw_sum + TO + 1;
        else                     exp_cyc = NTOT + nelig + rw_sum + lat_sum + 1;

        chk($sformatf("%s_done_count", name), done_cnt, 1);
        chk($sformatf("%s_done_cycle", name), first_done, exp_cyc);
        chk($sformatf("%s_req_count", name), oa.size(), exp_pairs);
        chk($sformatf("%s_pair_order", name), mism, 0);
        chk($sformatf("%s_req_stable", name), stab_err, 0);
        chk($sformatf("%s_one_outstanding", name), multi_err, 0);
        chk($sformatf("%s_pairs_issued", name), pairs_issued, exp_pairs);
        chk($sformatf("%s_hit_count", name), hit_count, exp_hits);
        chk($sformatf("%s_hit_pins", name), hit_pins, exp_hp);
        chk($sformatf("%s_timeout_err", name), timeout_err, (noresp && nelig > 0) ? 1 : 0);
        chk($sformatf("%s_busy_end", name), busy, 0);
        chk($sformatf("%s_req_valid_end", name), req_valid, 0);
        done_cyc = first_done;
    endtask

    initial begin
        int dc;
        logic [NP-1:0] ren, rmov;

        rst_in      = 1'b1;
        start       = 1'b0;
        ball_active = 1'b0;
        pins_en     = '0;
        pins_moving = '0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_hit    = 1'b0;
        repeat (3) @(negedge clk_in);

        // Reset state.
        chk("rst_req_valid", req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_hit_pins", hit_pins, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_pairs_issued", pairs_issued, 0);
        chk("rst_a_idx", req_a_idx, 0);
        chk("rst_b_idx", req_b_idx, 0);
        rst_in = 1'b0;
        @(negedge clk_in);

        // Nothing eligible: pure scan of all pairs.
        run_frame("empty", 1'b0, '0, '0, 0, 0, 1, 1, 0, 0, 0, 0, dc);
        chk("empty_done_at_56", dc, 56);

        // Single ball pair.
        run_frame("single", 1'b1, NP'(1), '0, 0, 0, 2, 2, 0, 0, 0, 1, dc);

        // Two moving pins among all enabled, resolver always hits.
        run_frame("allhit", 1'b1, {NP{1'b1}}, NP'(3), 0, 0, 1, 1, 0, 0, 0, 1, dc);
        chk("allhit_pairs_27", pairs_issued, 27);
        chk("allhit_pins_3ff", hit_pins, 10'h3FF);

        // Ready held low 5 cycles each request, spurious responses during ISSUE.
        run_frame("stall", 1'b1, {NP{1'b1}}, NP'(10'h024), 5, 5, 1, 3, 0, 1, 0, 0, dc);

        // Resolver never answers; then a good frame clears the sticky error.
        run_frame("timeout", 1'b1, {NP{1'b1}}, '0, 0, 2, 1, 1, 1, 0, 0, 0, dc);
        run_frame("recover", 1'b1, NP'(10'h0F0), NP'(10'h011), 0, 1, 1, 2, 0, 0, 0, 0, dc);

        // start pulses while busy must not restart the scan.
        run_frame("startbusy", 1'b1, NP'(10'h3C3), NP'(10'h101), 0, 2, 1, 3, 0, 0, 1, 0, dc);

        // Randomized frames.
        for (int k = 0; k < 8; k++) begin
            ren  = NP'($urandom) | NP'($urandom);
            rmov = NP'($urandom);
            run_frame($sformatf("rand%0d", k), 1'($urandom), ren, rmov,
                      0, 3, 1, 4, 0, k[0], k[1], 0, dc);
        end

        // Reset in the middle of WAIT.
        ball_active = 1'b1;
        pins_en     = {NP{1'b1}};
        pins_moving = '0;
        start       = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        for (int i = 0; i < 20 && req_valid !== 1'b1; i++) @(negedge clk_in);
        chk("rstwait_req_seen", req_valid, 1);
        req_ready = 1'b1;
        @(negedge clk_in);
        req_ready = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rstwait_busy_before", busy, 1);
        chk("rstwait_issued_before", pairs_issued, 1);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("rstwait_busy", busy, 0);
        chk("rstwait_req_valid", req_valid, 0);
        chk("rstwait_pairs_issued", pairs_issued, 0);
        chk("rstwait_hit_count", hit_count, 0);
        chk("rstwait_hit_pins", hit_pins, 0);
        chk("rstwait_a_idx", req_a_idx, 0);
        resp_valid = 1'b1;
        resp_hit   = 1'b1;
        @(negedge clk_in);
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        @(negedge clk_in);
        chk("late_resp_hit_count", hit_count, 0);
        chk("late_resp_hit_pins", hit_pins, 0);
        chk("late_resp_busy", busy, 0);
        chk("late_resp_done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/collision_pair_scheduler.md
Name: collision_pair_scheduler

Overview:
- Sequences the shared collision-resolve datapath over every ball-pin and pin-pin pair once per physics frame.
- Walks the pair list, skips pairs that cannot collide, and issues one request at a time over a valid/ready handshake.
- Waits for each result, then accumulates a hit mask and counters.
- Sits between the frame-tick controller and the resolver; the resolver is never driven without this block.

Parameters:
- NUM_PINS, 10, number of pins; ball index = NUM_PINS.
- IDX_W, 4, width of pair index fields; must hold NUM_PINS.
- TIMEOUT, 64, max cycles in WAIT before abort.
- CNT_W, 6, width of counters; must hold NUM_PINS + NUM_PINS*(NUM_PINS-1)/2 (55 at default).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- start  input  1  frame tick; begins a scan when idle.
- ball_active  input  1  ball on lane; latched at start.
- pins_en  input  NUM_PINS  pin in play; latched at start.
- pins_moving  input  NUM_PINS  pin velocity nonzero; latched at start.
- req_valid  output  1  pair request to resolver.
- req_a_idx  output  IDX_W  first object index (NUM_PINS = ball).
- req_b_idx  output  IDX_W  second object index (always a pin).
- req_ready  input  1  resolver accepts request.
- resp_valid  input  1  resolver result strobe.
- resp_hit  input  1  resolved pair collided.
- busy  output  1  scan in progress.
- done  output  1  one-cycle end-of-scan pulse.
- timeout_err  output  1  sticky: last scan aborted.
- hit_pins  output  NUM_PINS  pins involved in any hit this scan.
- hit_count  output  CNT_W  number of hit pairs this scan.
- pairs_issued  output  CNT_W  number of requests handshaken this scan.

Behaviour:
- Reset: state IDLE. All outputs are 0, including req_valid, busy, done, timeout_err, hit_pins and counters. Index registers are 0.
- Reset applies on any cycle, including mid-handshake. req_valid is low from the first cycle after the reset edge. Any later resp_valid is ignored.
- Pair order:
  - (BALL,0)..(BALL,NUM_PINS-1) first.
  - Then (0,1)..(0,9), (1,2)..(1,9), ..., (8,9).
  - 55 pairs at default.
- Eligibility:
  - Ball pair (BALL,b): ball_active & pins_en[b].
  - Pin pair (a,b): pins_en[a] & pins_en[b] & (pins_moving[a] | pins_moving[b]).
  - All three masks use the values latched at start.
- States:
  - IDLE: start=1 latches the masks and clears hit_pins, hit_count, pairs_issued and timeout_err. Pointer is set to (BALL,0); go to SCAN.
  - SCAN: evaluates one pair per cycle.
    - Eligible: go to ISSUE with the pointer held.
    - Ineligible and not last pair: advance the pointer, stay in SCAN.
    - Ineligible and last pair: go to DONE.
  - ISSUE: req_valid=1. req_a_idx/req_b_idx are stable and equal to the pointer until req_valid&req_ready. On the handshake: pairs_issued++, clear the timer, go to WAIT.
  - WAIT: req_valid=0; timer increments each cycle.
    - resp_valid=1: if resp_hit, hit_count++ and hit_pins[b]=1, and hit_pins[a]=1 if a≠BALL. Then advance the pointer and go to SCAN, or go to DONE if this was the last pair.
    - resp_valid=0 with timer==TIMEOUT-1: timeout_err=1, go to DONE.
  - DONE: done=1 for exactly this one cycle, then IDLE.
- busy=1 in SCAN/ISSUE/WAIT/DONE.
- start is ignored unless in IDLE. resp_valid is ignored outside WAIT. resp_valid in the same cycle as the ISSUE handshake is ignored.
- Only one request is outstanding at a time.
- Outputs hold their final values after DONE until the next accepted start.
- timeout_err holds until the next accepted start or reset.
- Counters saturate at 2^CNT_W-1; this is unreachable at default.

Test Plan:
- Reset, then start with ball_active=0 and pins_en=0: no req_valid ever. done=1 exactly 56 cycles after the start edge (55 SCAN cycles + DONE); pairs_issued=0.
- ball_active=1, pins_en=10'h001, pins_moving=0, resolver ready=1 with 2-cycle latency and resp_hit=1: exactly one request (a=10, b=0). Result hit_pins=10'h001, hit_count=1, pairs_issued=1, done pulses once.
- All pins enabled, ball_active=1, pins_moving=10'h003, resolver always hits after 1 cycle:
  - Ball pairs 10, plus (0,1..9) 9, plus (1,2..9) 8: pairs_issued=27, hit_count=27.
  - hit_pins=10'h3FF.
  - Issued indices match the defined order.
- req_ready held low 5 cycles in ISSUE: req_valid stays high and indices stay constant. A resp_valid pulse during ISSUE does not change hit_count.
- Resolver never responds: timeout_err=1 and done after TIMEOUT cycles in WAIT. Then start again with a good resolver: timeout_err clears at the accepted start.
- rst_in asserted in WAIT: busy=0 and req_valid=0 the next cycle, all counters 0. A late resp_valid changes nothing. start while busy is ignored; the scan is not restarted.
